// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate divider, H/V counters, raw sync decode
// and a tick-advanced delay line aligning sync/blank with the drawers' RGB pipe.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        pixelEn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        visible,
  output logic        startOfFrame,
  output logic        hSyncN,
  output logic        vSyncN,
  output logic        blankN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // SYNC_DELAY=0 still keeps one tick-enabled register on the outputs.
  localparam int STAGES  = (SYNC_DELAY == 0) ? 1 : SYNC_DELAY;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic vis;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0};

  logic [DIV_W-1:0]  div_q, div_d;
  logic [10:0]       h_q, h_d;
  logic [10:0]       v_q, v_d;
  logic              pe_q;
  logic              sof_q;
  sync_t [STAGES-1:0] dly_q;

  logic  tick;
  logic  line_end;
  logic  frame_end;
  sync_t raw;

  // Divider and tick; with CLK_DIV=1 DIV_LAST is 0, so tick follows enable.
  always_comb begin
    tick  = enable && (div_q == DIV_LAST);
    div_d = div_q;
    if (enable) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end
  end

  always_comb begin
    line_end  = (h_q == H_LAST);
    frame_end = line_end && (v_q == V_LAST);
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (line_end) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
    end
  end

  always_comb begin
    raw      = SYNC_IDLE;
    raw.hs_n = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    raw.vs_n = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    raw.vis  = (h_q < H_VIS) && (v_q < V_VIS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      pe_q  <= 1'b0;
      sof_q <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      pe_q  <= tick;
      sof_q <= tick && frame_end;
    end
  end

  // Delay line only moves on ticks, so its lag is measured in pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) dly_q[k] <= SYNC_IDLE;
    end else if (tick) begin
      dly_q[0] <= raw;
      for (int k = 1; k < STAGES; k++) dly_q[k] <= dly_q[k-1];
    end
  end

  assign pixelEn      = pe_q;
  assign pixelX       = h_q;
  assign pixelY       = v_q;
  assign visible      = raw.vis;
  assign startOfFrame = sof_q;
  assign hSyncN       = dly_q[STAGES-1].hs_n;
  assign vSyncN       = dly_q[STAGES-1].vs_n;
  assign blankN       = dly_q[STAGES-1].vis;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three geometries checked every clk against a
// pixel-index reference model, plus directed line/freeze/frame measurements.
module tb_vga_timing_gen;

  localparam int NI = 3;
  localparam int HA [NI] = '{640, 8, 8};
  localparam int HFP[NI] = '{16, 2, 2};
  localparam int HSY[NI] = '{96, 3, 3};
  localparam int HBP[NI] = '{48, 2, 2};
  localparam int VA [NI] = '{480, 4, 4};
  localparam int VFP[NI] = '{10, 1, 1};
  localparam int VSY[NI] = '{2, 2, 2};
  localparam int VBP[NI] = '{33, 1, 1};
  localparam int CD [NI] = '{2, 1, 3};
  localparam int SD [NI] = '{2, 0, 5};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic        pe [NI];
  logic [10:0] px [NI];
  logic [10:0] py [NI];
  logic        vis[NI];
  logic        sof[NI];
  logic        hs [NI];
  logic        vs [NI];
  logic        bl [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_timing_gen #(
      .H_ACTIVE(HA[g]), .H_FP(HFP[g]), .H_SYNC(HSY[g]), .H_BP(HBP[g]),
      .V_ACTIVE(VA[g]), .V_FP(VFP[g]), .V_SYNC(VSY[g]), .V_BP(VBP[g]),
      .CLK_DIV(CD[g]), .SYNC_DELAY(SD[g])
    ) u_dut (
      .clk(clk), .reset(reset), .enable(enable),
      .pixelEn(pe[g]), .pixelX(px[g]), .pixelY(py[g]), .visible(vis[g]),
      .startOfFrame(sof[g]), .hSyncN(hs[g]), .vSyncN(vs[g]), .blankN(bl[g])
    );
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state: enabled clks and pixel ticks since the last reset.
  longint en_cnt[NI];
  longint pix[NI];
  bit     m_pe[NI];
  bit     m_sof[NI];

  task automatic chk(input string tag, input int inst, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s[%0d] cyc=%0d got=%0d expected=%0d", tag, inst, cyc, got, exp);
    end
  endtask

  function automatic void model_step(input bit en, input bit rst);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        en_cnt[i] = 0; pix[i] = 0; m_pe[i] = 0; m_sof[i] = 0;
      end else if (en) begin
        bit tk;
        en_cnt[i]++;
        tk = (en_cnt[i] % CD[i]) == 0;
        m_pe[i] = tk;
        if (tk) pix[i]++;
        m_sof[i] = tk && (pix[i] % ((HA[i]+HFP[i]+HSY[i]+HBP[i]) * (VA[i]+VFP[i]+VSY[i]+VBP[i])) == 0);
      end else begin
        m_pe[i] = 0; m_sof[i] = 0;
      end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      longint ht, vt, x, y, m, mx, my;
      bit hs_e, vs_e, bl_e;
      ht = HA[i] + HFP[i] + HSY[i] + HBP[i];
      vt = VA[i] + VFP[i] + VSY[i] + VBP[i];
      x = pix[i] % ht;
      y = (pix[i] / ht) % vt;
      m = pix[i] - ((SD[i] == 0) ? 1 : SD[i]);
      hs_e = 1; vs_e = 1; bl_e = 0;
      if (m >= 0) begin
        mx = m % ht;
        my = (m / ht) % vt;
        hs_e = !(mx >= HA[i] + HFP[i] && mx < HA[i] + HFP[i] + HSY[i]);
        vs_e = !(my >= VA[i] + VFP[i] && my < VA[i] + VFP[i] + VSY[i]);
        bl_e = (mx < HA[i]) && (my < VA[i]);
      end
      chk("pe",  i, 64'(pe[i]),  64'(m_pe[i]));
      chk("px",  i, 64'(px[i]),  64'(x));
      chk("py",  i, 64'(py[i]),  64'(y));
      chk("vis", i, 64'(vis[i]), 64'((x < HA[i]) && (y < VA[i])));
      chk("sof", i, 64'(sof[i]), 64'(m_sof[i]));
      chk("hs",  i, 64'(hs[i]),  64'(hs_e));
      chk("vs",  i, 64'(vs[i]),  64'(vs_e));
      chk("bl",  i, 64'(bl[i]),  64'(bl_e));
    end
  endtask

  // Drive one clk's inputs, advance the model, then compare at the negedge.
  task automatic step(input logic en, input logic rst);
    enable = en;
    reset  = rst;
    model_step(en, rst);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  initial begin
    int n_pe, n_hslo, n_blhi, n_frz_pe, last[NI], n_sof[NI];
    bit found;

    // Power-on reset, some running, then a 3-clk reset mid-line.
    repeat (2) step(1'b0, 1'b1);
    repeat (300) step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1);
    chk("rst_px", 0, 64'(px[0]), 0);
    chk("rst_hs", 0, 64'(hs[0]), 1);
    chk("rst_vs", 0, 64'(vs[0]), 1);
    chk("rst_bl", 0, 64'(bl[0]), 0);
    chk("rst_vis", 0, 64'(vis[0]), 1);

    // One full line of the 640x480 instance.
    n_pe = 0; n_hslo = 0; n_blhi = 0;
    for (int k = 0; k < 1600; k++) begin
      step(1'b1, 1'b0);
      if (pe[0]) begin
        n_pe++;
        if (n_pe == 1) chk("first_px", 0, 64'(px[0]), 1);
        if (!hs[0]) n_hslo++;
        if (bl[0]) n_blhi++;
      end
    end
    chk("line_pe", 0, 64'(n_pe), 800);
    chk("line_px", 0, 64'(px[0]), 0);
    chk("line_py", 0, 64'(py[0]), 1);
    chk("hs_width", 0, 64'(n_hslo), 96);
    chk("bl_width", 0, 64'(n_blhi), 640);

    // Freeze at pixelX=100 for 37 clks.
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      step(1'b1, 1'b0);
      if (px[0] == 11'd100) found = 1;
    end
    chk("frz_reach", 0, 64'(found), 1);
    n_frz_pe = 0;
    for (int k = 0; k < 37; k++) begin
      step(1'b0, 1'b0);
      for (int i = 0; i < NI; i++) if (pe[i] || sof[i]) n_frz_pe++;
    end
    chk("frz_px", 0, 64'(px[0]), 100);
    chk("frz_pe", 0, 64'(n_frz_pe), 0);
    repeat (50) step(1'b1, 1'b0);

    // Frame period on the small geometries with enable held high.
    for (int i = 0; i < NI; i++) begin last[i] = -1; n_sof[i] = 0; end
    for (int k = 0; k < 800; k++) begin
      step(1'b1, 1'b0);
      for (int i = 1; i < NI; i++) if (sof[i]) begin
        n_sof[i]++;
        if (last[i] >= 0) chk("sof_per", i, 64'(cyc - last[i]), 64'(120 * CD[i]));
        last[i] = cyc;
      end
    end
    chk("sof_cnt", 1, 64'(n_sof[1] >= 6), 1);
    chk("sof_cnt", 2, 64'(n_sof[2] >= 2), 1);

    // Randomized enable with occasional asynchronous resets.
    for (int k = 0; k < 15000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b1);
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
